uart_resp_framer: RTL
=====================

Name: uart_resp_framer

Overview:
Transmit-side packet framer for the UART ALU datapath. It accepts one ALU result word through a valid/ready handshake and serializes it into a fixed-length byte packet: a 4-byte header followed by the data bytes, least-significant byte first. The byte stream is an AXI-Stream master that drives the s_axis_* inputs of uart_tx (DATA_WIDTH 8). It is the outbound counterpart of the byte-receive path that feeds the ALU.

Parameters:
RESP_OPCODE, 8'hA5, first header byte of every response packet.
NUM_DATA_BYTES, 4, number of result bytes per packet; the result width is 8*NUM_DATA_BYTES. Legal range is 1..251.

Ports:
clk_i  input  1  system clock; all logic is clocked on the rising edge.
rst_i  input  1  synchronous, active-high reset.
result_i  input  8*NUM_DATA_BYTES  result word to send.
result_valid_i  input  1  result_i is valid.
result_ready_o  output  1  framer can accept a result.
m_axis_tdata_o  output  8  current packet byte, to uart_tx s_axis_tdata.
m_axis_tvalid_o  output  1  byte valid, to uart_tx s_axis_tvalid.
m_axis_tready_i  input  1  byte accepted, from uart_tx s_axis_tready.
busy_o  output  1  a packet is in flight.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Packet layout, with LEN = 4 + NUM_DATA_BYTES:
  - byte 0 = RESP_OPCODE
  - byte 1 = 8'h00
  - byte 2 = LEN[7:0]
  - byte 3 = LEN[15:8]
  - bytes 4..LEN-1 = result bytes, result[7:0] first
  - With the defaults the header is A5 00 08 00.
- Reset values: the FSM is in IDLE. result_ready_o=1, m_axis_tvalid_o=0, m_axis_tdata_o=8'h00, busy_o=0. The byte index and the captured result register are 0.
- State machine:
  - IDLE:
    - result_ready_o=1, tvalid=0, busy=0.
    - On result_valid_i && result_ready_o: capture result_i into an internal register, set idx=0, go to SEND.
  - SEND:
    - result_ready_o=0, busy=1, tvalid=1.
    - tdata = packet byte [idx], taken from registered state only. There is no combinational path from result_i to tdata.
    - On tvalid && tready: if idx == LEN-1, go to IDLE; otherwise idx = idx+1.
- Latency:
  - The capture edge is N. tvalid=1 with byte 0 from cycle N+1.
  - With tready held at 1, the packet occupies LEN consecutive cycles.
  - result_ready_o returns to 1 on the cycle after the last byte handshake. This gives a fixed one-cycle bubble between packets.
- AXI-Stream rules:
  - Once tvalid is asserted it stays asserted, and tdata stays stable, until the handshake completes.
  - tvalid never depends combinationally on tready.
- Input changes during SEND: changes on result_i and result_valid_i are ignored. Only the captured copy is transmitted.
- A held result_valid_i during SEND is accepted in the first IDLE cycle (back-to-back packets).
- Reset mid-packet:
  - The framer returns to IDLE on the next edge and tvalid drops.
  - No further bytes of the aborted packet are emitted.
  - The next packet starts at byte 0.
- The idx counter is sized to hold LEN-1. It never wraps within a packet.

Test Plan:
- Single packet: result_i=32'hDEADBEEF pulsed valid for 1 cycle, tready=1 -> 8 consecutive beats A5 00 08 00 EF BE AD DE. tvalid rises one cycle after capture. busy_o is high for exactly 8 cycles.
- Backpressure: same packet, tready toggling 1,0,0,1,... -> the same 8-byte sequence. tdata and tvalid are stable on every stalled cycle. No byte is duplicated or skipped.
- Back-to-back: result_valid_i held high with 32'h11223344, then 32'h55667788 -> the second value is accepted exactly one cycle after the last byte of the first packet. The second packet's data bytes are 88 77 66 55.
- Input change while busy: change result_i to 32'hFFFFFFFF during SEND -> the in-flight packet still carries the originally captured bytes.
- Reset mid-packet: assert rst_i for 1 cycle after 3 accepted bytes -> tvalid=0 and result_ready_o=1 on the next cycle. The following result restarts at byte A5.
- Parameter sweep: NUM_DATA_BYTES=1, RESP_OPCODE=8'h3C, result 8'h7E -> the packet is 3C 00 05 00 7E.

Source files
------------

// File: rtl/uart_resp_framer.sv
// Response packet framer: captures one result word and streams it as
// a header + little-endian data byte packet on an AXI-Stream master.
module uart_resp_framer #(
  parameter logic [7:0]  RESP_OPCODE    = 8'hA5,
  parameter int unsigned NUM_DATA_BYTES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [8*NUM_DATA_BYTES-1:0] result_i,
  input  logic                        result_valid_i,
  output logic                        result_ready_o,
  output logic [7:0]                  m_axis_tdata_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i,
  output logic                        busy_o
);

  localparam int unsigned LEN = 4 + NUM_DATA_BYTES;
  localparam int unsigned IW  = $clog2(LEN);
  localparam int unsigned NB  = 1 << IW;
  localparam logic [15:0] LEN16 = 16'(LEN);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e                      state_q;
  logic [IW-1:0]               idx_q;
  logic [8*NUM_DATA_BYTES-1:0] data_q;
  logic [7:0]                  tdata_q;
  logic                        tvalid_q;
  logic                        ready_q;
  logic                        busy_q;

  logic [NB-1:0][7:0] pkt;
  logic [IW-1:0]      idx_d;

  // Packet image built only from the captured copy, padded to 2**IW.
  always_comb begin
    pkt    = '0;
    pkt[0] = RESP_OPCODE;
    pkt[1] = 8'h00;
    pkt[2] = LEN16[7:0];
    pkt[3] = LEN16[15:8];
    for (int i = 0; i < NUM_DATA_BYTES; i++) begin
      pkt[4+i] = data_q[8*i +: 8];
    end
  end

  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (result_valid_i && ready_q) begin
            data_q   <= result_i;
            idx_q    <= '0;
            tdata_q  <= RESP_OPCODE;
            tvalid_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          if (tvalid_q && m_axis_tready_i) begin
            if (idx_q == LAST) begin
              idx_q    <= '0;
              tdata_q  <= 8'h00;
              tvalid_q <= 1'b0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              idx_q   <= idx_d;
              tdata_q <= pkt[idx_d];
            end
          end
        end
      endcase
    end
  end

  assign result_ready_o  = ready_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign busy_o          = busy_q;

endmodule
